// File: rtl/uart_tx_strobed_if.sv
// Producer-side word handshake for the strobe-paced UART transmitter.
interface uart_tx_strobed_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_strobed.sv
// Strobe-paced UART transmitter: one bit per tick, one-word holding register
// so the next frame can follow the current one without an idle bit.
module uart_tx_strobed #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  uart_tx_strobed_if.slave    bus,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic [DATA_WIDTH-1:0] hold, hold_n;
  logic                  hold_full, hold_full_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic                  stop_cnt, stop_cnt_n;
  logic                  par, par_n;
  logic                  tx_n;
  logic                  accept;
  logic                  load;

  assign accept         = bus.data_valid && !hold_full;
  assign bus.data_ready = !hold_full;
  assign busy           = (state != IDLE) || hold_full;

  // State, datapath and line register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par       <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      par       <= par_n;
      tx        <= tx_n;
    end
  end

  // Next-state logic: hold capture every cycle, frame sequencing on tick only.
  always_comb begin
    state_n     = state;
    sh_n        = sh;
    hold_n      = hold;
    hold_full_n = hold_full;
    bit_cnt_n   = bit_cnt;
    stop_cnt_n  = stop_cnt;
    par_n       = par;
    tx_n        = tx;
    load        = 1'b0;

    if (accept) begin
      hold_n      = bus.data;
      hold_full_n = 1'b1;
    end

    if (tick) begin
      case (state)
        IDLE: load = hold_full;
        START: begin
          tx_n      = sh[0];
          bit_cnt_n = '0;
          state_n   = DATA;
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            if (PARITY != 0) begin
              tx_n    = par;
              state_n = PAR;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = STOP;
            end
          end else begin
            sh_n      = sh >> 1;
            tx_n      = sh[1];
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
        PAR: begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
        STOP: begin
          if (stop_cnt == STOP_LAST) begin
            if (hold_full) load = 1'b1;
            else           state_n = IDLE;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Parity is fixed from the word as it leaves the holding register.
    if (load) begin
      sh_n        = hold;
      hold_full_n = 1'b0;
      tx_n        = 1'b0;
      par_n       = (PARITY == 1) ? ~^hold : ^hold;
      state_n     = START;
    end
  end

endmodule

// File: tb/tb_uart_tx_strobed.sv
// Directed bench for uart_tx_strobed: 8N1, 8E2 and 8O1 instances share clk,
// rst and a strobe-counter tick source; serial bits are compared per tick.
module tb_uart_tx_strobed;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  int   tick_period = 0;
  int   cws_cnt;
  int   n_cmp = 0;
  int   n_err = 0;
  int   sel = 0;
  logic pre_ready, pre_busy;
  logic tx0, tx1, tx2, busy0, busy1, busy2;
  logic tx_s, busy_s, ready_s;

  uart_tx_strobed_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_strobed_if #(.DATA_WIDTH(8)) bus1 ();
  uart_tx_strobed_if #(.DATA_WIDTH(8)) bus2 ();

  uart_tx_strobed #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .bus(bus0.slave), .tx(tx0), .busy(busy0));
  uart_tx_strobed #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .bus(bus1.slave), .tx(tx1), .busy(busy1));
  uart_tx_strobed #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .bus(bus2.slave), .tx(tx2), .busy(busy2));

  always #5 clk = ~clk;

  // Bench model of counter_with_strobe: one-cycle strobe every tick_period clocks.
  initial begin
    tick    = 1'b0;
    cws_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_period <= 0) begin
        tick    = 1'b0;
        cws_cnt = 0;
      end else if (cws_cnt == 0) begin
        tick    = 1'b1;
        cws_cnt = tick_period - 1;
      end else begin
        tick    = 1'b0;
        cws_cnt = cws_cnt - 1;
      end
    end
  end

  // Route the selected instance's outputs to common observation signals.
  always_comb begin
    case (sel)
      1:       begin tx_s = tx1; busy_s = busy1; ready_s = bus1.data_ready; end
      2:       begin tx_s = tx2; busy_s = busy2; ready_s = bus2.data_ready; end
      default: begin tx_s = tx0; busy_s = busy0; ready_s = bus0.data_ready; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [7:0] d, input logic v);
    case (idx)
      1:       begin bus1.data = d; bus1.data_valid = v; end
      2:       begin bus2.data = d; bus2.data_valid = v; end
      default: begin bus0.data = d; bus0.data_valid = v; end
    endcase
  endtask

  // Offer a word to the selected instance; entered and left at a negedge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    drive(sel, d, 1'b1);
    while (!ready_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, d, 1'b0);
  endtask

  // Wait for the next tick cycle and return tx as driven after its edge.
  task automatic next_bit(output logic b);
    int n = 0;
    while (tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("tick_timeout", 32'd0, 32'd1);
      b = 1'bx;
    end else begin
      pre_ready = ready_s;
      pre_busy  = busy_s;
      @(posedge clk);
      #2 b = tx_s;
      @(negedge clk);
    end
  endtask

  // Collect nbits serial bits (bit i = i-th tick) and compare as a vector.
  task automatic check_frame(input string tag, input logic [31:0] exp, input int nbits);
    logic        b;
    logic [31:0] got;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      next_bit(b);
      got[i] = b;
    end
    check(tag, got, exp);
  endtask

  // Final stop tick: busy still high in that cycle, low right after its edge.
  task automatic end_frame(input string tag);
    int n = 0;
    while (tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_pre"}, 32'(busy_s), 32'd1);
    @(posedge clk);
    #2 check({tag, "_busy_post"}, 32'(busy_s), 32'd0);
    check({tag, "_ready_post"}, 32'(ready_s), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       b;
    logic [7:0] rx;
    logic       samp [50];
    int         n;
    int         run;

    rst = 1'b1;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx0), 32'd1);
    check("rst_ready", 32'(bus0.data_ready), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_tx_e2", 32'(tx1), 32'd1);
    rst = 1'b0;
    tick_period = 4;
    repeat (6) @(negedge clk);

    // 8N1, 0x55: 0,1,0,1,0,1,0,1,0,1
    sel = 0;
    send(8'h55);
    check("n1_busy_after_accept", 32'(busy_s), 32'd1);
    check_frame("n1_0x55", 32'h2AA, 10);
    end_frame("n1");

    // Back-to-back 0xA3 then 0x0F, second accepted during data bits
    send(8'hA3);
    check_frame("bb_f1_head", 32'h006, 3);
    send(8'h0F);
    check("bb_ready_low_after_accept", 32'(ready_s), 32'd0);
    check_frame("bb_f1_tail", 32'h068, 7);
    check("bb_ready_low_at_stop", 32'(ready_s), 32'd0);
    next_bit(b);
    check("bb_no_idle_start", 32'(b), 32'd0);
    check("bb_ready_low_in_load_tick", 32'(pre_ready), 32'd0);
    check("bb_ready_high_after_load", 32'(ready_s), 32'd1);
    check_frame("bb_f2_rest", 32'h10F, 9);
    end_frame("bb");

    // 8E2 0x03 (parity 0, two stops); 8O1 0x03 (parity 1) and 0x07 (parity 0)
    sel = 1;
    send(8'h03);
    check_frame("e2_0x03", 32'hC06, 12);
    end_frame("e2");
    sel = 2;
    send(8'h03);
    check_frame("o1_0x03", 32'h606, 11);
    end_frame("o1a");
    send(8'h07);
    check_frame("o1_0x07", 32'h40E, 11);
    end_frame("o1b");

    // Accept 0x81 on an IDLE tick cycle: not sent on that tick
    sel = 0;
    n = 0;
    while (tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    drive(0, 8'h81, 1'b1);
    @(posedge clk);
    #2;
    check("st_tx_stays_high", 32'(tx_s), 32'd1);
    check("st_captured", 32'(ready_s), 32'd0);
    @(negedge clk);
    drive(0, 8'h81, 1'b0);
    check("st_tx_high_before_next", 32'(tx_s), 32'd1);
    check_frame("st_0x81", 32'h302, 10);
    end_frame("st");

    // Asynchronous reset during data bit 4 with a word held
    send(8'h0F);
    check_frame("ar_head", 32'h002, 2);
    send(8'h99);
    check("ar_hold_full", 32'(ready_s), 32'd0);
    check_frame("ar_bits", 32'h007, 4);
    check("ar_tx_bit4", 32'(tx_s), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("ar_tx", 32'(tx_s), 32'd1);
    check("ar_ready", 32'(ready_s), 32'd1);
    check("ar_busy", 32'(busy_s), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h5A);
    check_frame("ar_clean_0x5A", 32'h2B4, 10);
    end_frame("ar");

    // Strobe counter at reset_value 5, bench receiver decodes 0xC4
    tick_period = 5;
    repeat (12) @(negedge clk);
    send(8'hC4);
    n = 0;
    while (tx_s !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_start_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 50; i++) begin
      samp[i] = tx_s;
      @(negedge clk);
    end
    run = 0;
    while (run < 50 && samp[run] == 1'b0) run++;
    check("rx_low_run_3bits", 32'(run), 32'd15);
    n = 0;
    while (run + n < 50 && samp[run + n] == 1'b1) n++;
    check("rx_bit2_width", 32'(n), 32'd5);
    check("rx_start_mid", 32'(samp[2]), 32'd0);
    for (int k = 0; k < 8; k++) rx[k] = samp[2 + 5 * (k + 1)];
    check("rx_data_0xC4", 32'(rx), 32'hC4);
    check("rx_stop_mid", 32'(samp[47]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_strobed.md
# uart_tx_strobed

Strobe-paced serial transmitter: serialises parallel words into UART frames (start, LSB-first data, optional parity, stop bits), advancing one bit per `tick` pulse. It sits directly downstream of `counter_with_strobe`. That counter's `strobe` output, held at the baud period, drives `tick`, so bit timing is set entirely by the counter's `reset_value`. A one-word holding register lets a producer queue the next word while the current frame shifts out, giving gap-free back-to-back frames.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5–16.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

Ports:
- `clk`, input, 1: single clock domain.
- `rst`, input, 1: reset; one clock; asynchronous, active-high.
- `tick`, input, 1: one-cycle bit-period pulse, from `counter_with_strobe.strobe`.
- `data`, input, `DATA_WIDTH`: word to send.
- `data_valid`, input, 1: producer offers `data`.
- `data_ready`, output, 1: holding register empty; transfer occurs when `data_valid && data_ready`.
- `tx`, output, 1: serial line, registered, idles high.
- `busy`, output, 1: high while a frame is in flight or a word is held.

## Operation
- Holding register `hold`, flag `hold_full`:
  - `data_ready = !hold_full`.
  - On accept, `hold <= data` and `hold_full <= 1`.
- FSM states: IDLE, START, DATA, PAR, STOP. Counters: `bit_cnt` (0..DATA_WIDTH-1) and `stop_cnt` (0..STOP_BITS-1). Shift register `sh` of `DATA_WIDTH` bits.
- The FSM advances only on cycles where `tick` is high. It holds state otherwise.
- IDLE + tick + `hold_full`:
  - `sh <= hold`, `hold_full <= 0`.
  - `tx <= 0`, go to START.
- IDLE + tick + empty hold: no change; `tx` stays 1.
- START + tick: `tx <= sh[0]`, `bit_cnt <= 0`, go to DATA.
- DATA + tick, `bit_cnt < DATA_WIDTH-1`: shift `sh` right, `tx <=` next bit, `bit_cnt++`.
- DATA + tick, `bit_cnt == DATA_WIDTH-1`:
  - If PARITY ≠ 0: `tx <=` parity bit, go to PAR.
  - Otherwise: `tx <= 1`, `stop_cnt <= 0`, go to STOP.
- Parity bit is computed over the word latched at frame start:
  - Even: XOR of all data bits.
  - Odd: inverse of that XOR.
- PAR + tick: `tx <= 1`, `stop_cnt <= 0`, go to STOP.
- STOP + tick, `stop_cnt < STOP_BITS-1`: `stop_cnt++`; `tx` stays 1.
- STOP + tick, last stop bit:
  - If `hold_full`: load as in IDLE (`tx <= 0`, go to START), giving a back-to-back frame with no idle bit.
  - Otherwise: go to IDLE.
- `busy = (state != IDLE) || hold_full`, combinational from registers.
- Simultaneous accept and IDLE tick with the hold empty: the word is captured but not sent on that tick. START begins on the next tick.
- Simultaneous accept and hold-to-shifter load: impossible, because `data_ready` is 0 while `hold_full` is set. The hold frees on the cycle after the load.
- Reset asserted at any time, including mid-frame:
  - Abort the frame immediately and discard the held word.
  - State = IDLE, `tx = 1`, `hold_full = 0`, counters = 0.

## Timing
- Reset values: `tx = 1`, `data_ready = 1`, `busy = 0`.
- `tx` changes only on the clock edge at the end of a cycle in which `tick` is high.
- Each bit is held for exactly one tick interval.
- Frame length is 1 + DATA_WIDTH + (PARITY ≠ 0) + STOP_BITS ticks.
- Latency from accept (hold empty, FSM idle) to the start bit on `tx` is the first tick at least one cycle after accept, plus one clock.
- `data_ready` rises one clock after the load tick.
- `busy` falls one clock after the final stop tick when no word is held.
- `tick` pulses closer than 2 cycles apart are legal. The FSM still advances once per tick cycle.
- Maximum sustained throughput is one word per frame length in ticks.

## Test plan
- 8N1, `tick` every 4 cycles, send 0x55:
  - `tx` sequence per tick is 0,1,0,1,0,1,0,1,0,1.
  - `busy` is high for exactly 10 ticks plus 1 cycle.
- Back-to-back 0xA3 then 0x0F, second word accepted during the first frame's data bits:
  - No idle bit between frames.
  - `data_ready` is low from the second accept until the second frame's start tick + 1.
- PARITY=2 with 0x03 gives parity bit 0. PARITY=1 with 0x03 gives 1. PARITY=1 with 0x07 gives 0. STOP_BITS=2 gives two high bit periods.
- Accept 0x81 on the same cycle as an IDLE tick:
  - `tx` stays 1 for that tick.
  - Start bit appears after the next tick.
- Reset pulse (asynchronous, mid-cycle) during data bit 4 of a frame with a word held:
  - `tx = 1`, `data_ready = 1`, `busy = 0` immediately.
  - The next accepted word transmits a clean full frame.
- Integration with `counter_with_strobe` (`reset_value = 5`, `enable` = 1):
  - Each bit is 5 clocks wide.
  - Frame for 0xC4 decodes correctly via a bench-side UART receiver model.
